// File: rtl/miner_job_master.sv
// Avalon-MM master that pushes a buffered job plus GO into miner_0, waits out bsy, then reads the results back.
// Latency: start-to-done is about JOB_WORDS+RES_WORDS*2+bsy time+4 cycles; every Avalon strobe holds while waitrequest is high.
module miner_job_master #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 8,
   parameter int JOB_WORDS = 20,
   parameter int RES_WORDS = 2,
   parameter int JOB_BASE  = 0,
   parameter int RES_BASE  = 32,
   parameter int CTRL_ADDR = 48,
   parameter int GO_VAL    = 1,
   parameter int BSY_WAIT  = 16,
   parameter int TIMEOUT_W = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              job_wr_en,
   input  logic [4:0]        job_wr_idx,
   input  logic [DATA_W-1:0] job_wr_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic              res_valid,
   output logic [1:0]        res_idx,
   output logic [DATA_W-1:0] res_data,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   output logic              avm_read,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest,
   input  logic              avm_readdatavalid,
   input  logic              miner_bsy
);

   localparam int HW = $clog2(BSY_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_JOB, S_WR_GO, S_WAIT_HI, S_WAIT_LO, S_RD_REQ, S_RD_WAIT, S_DONE
   } state_t;

   state_t state, nxt;

   logic [DATA_W-1:0]    job_buf [JOB_WORDS];
   logic [4:0]           k;
   logic [1:0]           j;
   logic [HW-1:0]        hi_cnt;
   logic [TIMEOUT_W-1:0] to_cnt;
   logic                 timeout_hit;

   assign timeout_hit = (state == S_WAIT_LO) && miner_bsy && (&to_cnt);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    if (start) nxt = S_WR_JOB;
         S_WR_JOB:  if (!avm_waitrequest && k == 5'(JOB_WORDS - 1)) nxt = S_WR_GO;
         S_WR_GO:   if (!avm_waitrequest) nxt = S_WAIT_HI;
         // A miner that finishes before we ever see bsy high must not stall us here.
         S_WAIT_HI: if (miner_bsy || hi_cnt == HW'(BSY_WAIT - 1)) nxt = S_WAIT_LO;
         S_WAIT_LO: begin
            if (!miner_bsy)   nxt = S_RD_REQ;
            else if (&to_cnt) nxt = S_IDLE;
         end
         S_RD_REQ:  if (!avm_waitrequest) nxt = S_RD_WAIT;
         S_RD_WAIT: if (avm_readdatavalid) nxt = (j == 2'(RES_WORDS - 1)) ? S_DONE : S_RD_REQ;
         S_DONE:    nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   always_comb begin
      avm_write     = 1'b0;
      avm_read      = 1'b0;
      avm_address   = '0;
      avm_writedata = '0;
      busy          = (state != S_IDLE);
      case (state)
         S_WR_JOB: begin
            avm_write     = 1'b1;
            avm_address   = ADDR_W'(JOB_BASE) + ADDR_W'(k);
            avm_writedata = job_buf[k];
         end
         S_WR_GO: begin
            avm_write     = 1'b1;
            avm_address   = ADDR_W'(CTRL_ADDR);
            avm_writedata = DATA_W'(GO_VAL);
         end
         S_RD_REQ: begin
            avm_read    = 1'b1;
            avm_address = ADDR_W'(RES_BASE) + ADDR_W'(j);
         end
         default: ;
      endcase
   end

   // Job words are payload only; leaving them out of reset keeps the buffer a plain RAM.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && job_wr_en && job_wr_idx < 5'(JOB_WORDS))
         job_buf[job_wr_idx] <= job_wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k           <= '0;
         j           <= '0;
         hi_cnt      <= '0;
         to_cnt      <= '0;
         err_timeout <= 1'b0;
         done        <= 1'b0;
         res_valid   <= 1'b0;
         res_idx     <= '0;
         res_data    <= '0;
      end else begin
         if (state != S_WR_JOB)     k <= '0;
         else if (!avm_waitrequest) k <= k + 5'd1;

         if (state == S_IDLE)                            j <= '0;
         else if (state == S_RD_WAIT && avm_readdatavalid) j <= j + 2'd1;

         hi_cnt <= (state == S_WAIT_HI) ? hi_cnt + HW'(1) : '0;
         to_cnt <= (state == S_WAIT_LO) ? to_cnt + TIMEOUT_W'(1) : '0;

         if (state == S_IDLE && start) err_timeout <= 1'b0;
         else if (timeout_hit)         err_timeout <= 1'b1;

         done      <= (state == S_DONE);
         res_valid <= (state == S_RD_WAIT) && avm_readdatavalid;
         if (state == S_RD_WAIT && avm_readdatavalid) begin
            res_idx  <= j;
            res_data <= avm_readdata;
         end
      end
   end

endmodule

// File: tb/tb_miner_job_master.sv
// Directed bench for miner_job_master: a small Avalon slave / miner model logs every accepted transfer.
module tb_miner_job_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_wr_en;
   logic [4:0]  job_wr_idx;
   logic [31:0] job_wr_data;
   logic        start;
   logic        busy, done, err_timeout, res_valid;
   logic [1:0]  res_idx;
   logic [31:0] res_data;
   logic [7:0]  avm_address;
   logic        avm_write, avm_read;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest, avm_readdatavalid, miner_bsy;

   miner_job_master #(.TIMEOUT_W(8)) dut (
      .clk(clk), .reset(reset),
      .job_wr_en(job_wr_en), .job_wr_idx(job_wr_idx), .job_wr_data(job_wr_data),
      .start(start), .busy(busy), .done(done), .err_timeout(err_timeout),
      .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
      .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid), .miner_bsy(miner_bsy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ws_mode = 0;    // 0 none, 1 random, 2 always
   int bsy_mode = 0;   // 0 ten-cycle pulse, 1 never, 2 stuck high

   // slave-side logs, written only by the slave process
   logic [7:0]  wa_q[$];
   logic [31:0] wd_q[$];
   logic [7:0]  ra_q[$];
   logic [1:0]  ri_q[$];
   logic [31:0] rdat_q[$];
   int cyc = 0, res_cyc = 0, done_cyc = 0, done_n = 0, viol = 0, bsy_c = 1000;

   function automatic logic [31:0] job_word(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [7:0] a);
      if (a == 8'd32) return 32'hDEAD_BEEF;
      if (a == 8'd33) return 32'h1234_5678;
      return 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Slave and miner model: observes at negedge, drives responses just after posedge.
   initial begin
      logic [7:0]  hold_a, rd_addr;
      logic [31:0] hold_d;
      bit pend_w, pend_r, rd_acc, go_acc;
      pend_w = 0; pend_r = 0; hold_a = '0; hold_d = '0; rd_addr = '0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; miner_bsy = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         rd_acc = 0; go_acc = 0;
         if (reset) begin
            pend_w = 0; pend_r = 0;
         end else begin
            if (avm_write && avm_read) viol++;
            if (pend_w && !(avm_write && avm_address == hold_a && avm_writedata == hold_d)) viol++;
            if (pend_r && !(avm_read && avm_address == hold_a)) viol++;
            pend_w = 0; pend_r = 0;
            if (avm_write) begin
               if (avm_waitrequest) begin
                  pend_w = 1; hold_a = avm_address; hold_d = avm_writedata;
               end else begin
                  wa_q.push_back(avm_address); wd_q.push_back(avm_writedata);
                  if (avm_address == 8'd48) go_acc = 1;
               end
            end
            if (avm_read) begin
               if (avm_waitrequest) begin
                  pend_r = 1; hold_a = avm_address;
               end else begin
                  ra_q.push_back(avm_address); rd_acc = 1; rd_addr = avm_address;
               end
            end
            if (res_valid) begin
               ri_q.push_back(res_idx); rdat_q.push_back(res_data); res_cyc = cyc;
            end
            if (done) begin
               done_n++; done_cyc = cyc;
            end
         end
         @(posedge clk); #1;
         avm_readdatavalid = rd_acc;
         avm_readdata      = rd_acc ? mem_rd(rd_addr) : 32'h0;
         avm_waitrequest   = (ws_mode == 2) ? 1'b1 : (ws_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (go_acc) bsy_c = 0;
         else if (bsy_c < 1000) bsy_c++;
         miner_bsy = (bsy_mode == 2) ? 1'b1 :
                     (bsy_mode == 0) ? (bsy_c >= 2 && bsy_c < 12) : 1'b0;
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base);
      for (int i = 0; i < 3000 && done_n == base; i++) tick();
      chk(tag, done_n - base, 1);
   endtask

   task automatic check_job(input string sc, input int wb, input int rb, input int qb, input int vb);
      chk({sc, "_wr_n"}, wa_q.size() - wb, 21);
      for (int i = 0; i < 21; i++) begin
         chk($sformatf("%s_wa%0d", sc, i), 32'(wa_q[wb + i]), (i < 20) ? i : 48);
         chk($sformatf("%s_wd%0d", sc, i), wd_q[wb + i], (i < 20) ? job_word(i) : 32'd1);
      end
      chk({sc, "_rd_n"}, ra_q.size() - rb, 2);
      chk({sc, "_ra0"}, 32'(ra_q[rb]), 32);
      chk({sc, "_ra1"}, 32'(ra_q[rb + 1]), 33);
      chk({sc, "_res_n"}, ri_q.size() - qb, 2);
      chk({sc, "_ri0"}, 32'(ri_q[qb]), 0);
      chk({sc, "_ri1"}, 32'(ri_q[qb + 1]), 1);
      chk({sc, "_rdat0"}, rdat_q[qb], 32'hDEAD_BEEF);
      chk({sc, "_rdat1"}, rdat_q[qb + 1], 32'h1234_5678);
      chk({sc, "_done_gap"}, done_cyc - res_cyc, 1);
      chk({sc, "_busy_after"}, busy, 0);
      chk({sc, "_viol"}, viol - vb, 0);
   endtask

   initial begin
      int wb, rb, qb, db, vb;
      reset = 1'b1; job_wr_en = 1'b0; job_wr_idx = '0; job_wr_data = '0; start = 1'b0;
      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_read", avm_read, 0);
      chk("rst_addr", 32'(avm_address), 0);
      chk("rst_wdata", avm_writedata, 0);
      chk("rst_res_idx", 32'(res_idx), 0);
      chk("rst_res_data", res_data, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 20; i++) begin
         job_wr_en = 1'b1; job_wr_idx = 5'(i); job_wr_data = job_word(i); tick();
      end
      job_wr_en = 1'b1; job_wr_idx = 5'd25; job_wr_data = 32'hFFFF_FFFF; tick();
      job_wr_en = 1'b0;

      // basic job, zero wait states
      wb = wa_q.size(); rb = ra_q.size(); qb = ri_q.size(); db = done_n; vb = viol;
      pulse_start();
      chk("s1_busy_start", busy, 1);
      wait_done("s1_done", db);
      tick(2);
      check_job("s1", wb, rb, qb, vb);

      // random waitrequest
      ws_mode = 1;
      wb = wa_q.size(); rb = ra_q.size(); qb = ri_q.size(); db = done_n; vb = viol;
      pulse_start();
      wait_done("s2_done", db);
      tick(2);
      check_job("s2", wb, rb, qb, vb);

      // bsy never rises
      ws_mode = 0; bsy_mode = 1;
      wb = wa_q.size(); rb = ra_q.size(); qb = ri_q.size(); db = done_n; vb = viol;
      pulse_start();
      wait_done("s3_done", db);
      tick(2);
      check_job("s3", wb, rb, qb, vb);

      // bsy stuck high -> timeout
      bsy_mode = 2;
      wb = wa_q.size(); rb = ra_q.size(); db = done_n;
      pulse_start();
      for (int i = 0; i < 3000 && busy; i++) tick();
      tick(3);
      chk("s4_err", err_timeout, 1);
      chk("s4_busy", busy, 0);
      chk("s4_no_reads", ra_q.size() - rb, 0);
      chk("s4_no_done", done_n - db, 0);
      chk("s4_writes", wa_q.size() - wb, 21);
      bsy_mode = 0;
      tick(2);
      wb = wa_q.size(); rb = ra_q.size(); qb = ri_q.size(); db = done_n; vb = viol;
      pulse_start();
      chk("s4_err_clr", err_timeout, 0);
      wait_done("s4b_done", db);
      tick(2);
      check_job("s4b", wb, rb, qb, vb);

      // start and buffer writes while busy are ignored
      wb = wa_q.size(); rb = ra_q.size(); qb = ri_q.size(); db = done_n; vb = viol;
      pulse_start();
      tick(4);
      start = 1'b1; job_wr_en = 1'b1; job_wr_idx = 5'd19; job_wr_data = 32'hBAD0_0019; tick();
      job_wr_idx = 5'd0; job_wr_data = 32'hBAD0_0000; tick();
      start = 1'b0; job_wr_en = 1'b0;
      wait_done("s5_done", db);
      tick(100);
      chk("s5_once", done_n - db, 1);
      check_job("s5", wb, rb, qb, vb);

      // reset in the middle of a stalled job write
      ws_mode = 2;
      pulse_start();
      tick(3);
      chk("s6_stall_wr", avm_write, 1);
      chk("s6_stall_addr", 32'(avm_address), 0);
      reset = 1'b1;
      tick();
      chk("s6_rst_write", avm_write, 0);
      chk("s6_rst_read", avm_read, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_addr", 32'(avm_address), 0);
      chk("s6_rst_wdata", avm_writedata, 0);
      chk("s6_rst_done", done, 0);
      reset = 1'b0; ws_mode = 0;
      tick(2);
      wb = wa_q.size(); rb = ra_q.size(); qb = ri_q.size(); db = done_n; vb = viol;
      pulse_start();
      wait_done("s6_done", db);
      tick(2);
      check_job("s6", wb, rb, qb, vb);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
